// File: rtl/mips_pkg.sv
// Shared types and defaults for the pipeline memory-port arbiter.
package mips_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   localparam int unsigned MAX_D_RUN_DEFAULT = 4;

endpackage

// File: rtl/arb_prio_fair.sv
// Grant selection between fetch and data, with a bounded run of data grants
// so that a pending fetch cannot be starved by back-to-back loads/stores.
module arb_prio_fair
   import mips_pkg::*;
#(
   parameter int unsigned MAX_D_RUN = MAX_D_RUN_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic d_req,
   input  logic is_idle,
   output logic grant_d,
   output logic grant_if
);

   localparam logic [3:0] RUN_MAX = 4'(MAX_D_RUN);

   logic [3:0] run_cnt_q;
   logic [3:0] run_cnt_d;

   // Data wins ties (older instruction) until it has used up its run budget.
   always_comb begin
      grant_d   = is_idle & d_req & (~if_req | (run_cnt_q < RUN_MAX));
      grant_if  = is_idle & if_req & ~grant_d;
      run_cnt_d = run_cnt_q;
      if (grant_if || (is_idle && !if_req)) begin
         run_cnt_d = '0;
      end else if (grant_d && (run_cnt_q < RUN_MAX)) begin
         run_cnt_d = run_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_cnt_q <= '0;
      end else begin
         run_cnt_q <= run_cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// One split-phase transaction in flight; results return with a one-cycle done pulse.
module mem_port_arbiter
   import mips_pkg::*;
#(
   parameter int unsigned AW        = 32,
   parameter int unsigned DW        = 32,
   parameter int unsigned MAX_D_RUN = MAX_D_RUN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic [DW-1:0]   if_rdata,
   output logic            if_done,
   output logic            if_stall,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic [DW-1:0]   d_rdata,
   output logic            d_done,
   output logic            mem_stall,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [DW-1:0]   mem_rdata
);

   arb_state_e      state_q, state_d;
   owner_e          owner_q, owner_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DW/8-1:0] mem_be_q, mem_be_d;
   logic [DW-1:0]   if_rdata_q, if_rdata_d;
   logic [DW-1:0]   d_rdata_q, d_rdata_d;
   logic            if_done_q, if_done_d;
   logic            d_done_q, d_done_d;
   logic            grant_d, grant_if;

   arb_prio_fair #(
      .MAX_D_RUN (MAX_D_RUN)
   ) u_prio (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .d_req    (d_req),
      .is_idle  (state_q == ARB_IDLE),
      .grant_d  (grant_d),
      .grant_if (grant_if)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_done_d   = 1'b0;
      d_done_d    = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (grant_d) begin
               owner_d     = OWN_D;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_be_d    = d_be;
               state_d     = ARB_ISSUE;
            end else if (grant_if) begin
               owner_d    = OWN_IF;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = if_addr;
               mem_be_d   = '1;
               state_d    = ARB_ISSUE;
            end
         end
         // Command stays frozen in the output registers until the memory takes it.
         ARB_ISSUE: begin
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               state_d   = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (mem_rvalid) begin
               if (owner_q == OWN_D) begin
                  d_rdata_d = mem_rdata;
                  d_done_d  = 1'b1;
               end else begin
                  if_rdata_d = mem_rdata;
                  if_done_d  = 1'b1;
               end
               state_d = ARB_RESP;
            end
         end
         ARB_RESP: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ARB_IDLE;
         owner_q     <= OWN_IF;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_done_q   <= if_done_d;
         d_done_q    <= d_done_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_done   = if_done_q;
   assign d_done    = d_done_q;

   // Stalls are combinational so the pipeline freezes in the same cycle a request appears.
   assign if_stall  = if_req & ~if_done_q;
   assign mem_stall = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: requester agents and a memory model feed a command and a
// response scoreboard that are checked as the DUT presents traffic.
module tb_mem_port_arbiter;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_done, if_stall;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_be = '0;
   logic [31:0] d_rdata;
   logic        d_done, mem_stall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_RUN(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rdata(d_rdata), .d_done(d_done), .mem_stall(mem_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int drop_after; } req_t;
   typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } cmd_t;
   typedef struct { bit is_d; bit chk_data; logic [31:0] rdata; int cyc; } resp_t;

   req_t  if_stim_q[$], d_stim_q[$];
   cmd_t  cmd_q[$];
   resp_t resp_q[$];
   req_t  if_cur, d_cur;
   logic [31:0] mem_model [logic [31:0]];

   int checks = 0, errors = 0;
   int cycle_cnt = 0, t0 = 0;
   int gnt_delay = 0, rv_delay = 0;
   int if_stall_cyc = 0, mem_stall_cyc = 0, mem_req_cyc = 0;
   int if_age = 0, d_age = 0, gcnt = 0, rv_wait = 0;
   bit if_busy = 0, d_busy = 0, rv_pending = 0;
   logic [31:0] rv_addr = '0;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle_cnt - t0);
      end
   endtask

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem_model.exists(a) ? mem_model[a] : 32'h0;
   endfunction

   task automatic take_done(input bit is_d, input logic [31:0] data);
      resp_t e;
      if (resp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL unexpected_done: got done owner=%0d expected none", is_d);
      end else begin
         e = resp_q.pop_front();
         chk("done_owner", 32'(is_d), 32'(e.is_d));
         if (e.chk_data) chk("rdata", data, e.rdata);
         chk("done_cycle", 32'(cycle_cnt - t0), 32'(e.cyc));
         $display("resp owner=%0d data=%h cycle=%0d", is_d, data, cycle_cnt - t0);
      end
   endtask

   // Memory model, requester agents, then (2 units later) the response monitor.
   always @(negedge clk) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst) begin
         rv_pending = 0; gcnt = 0;
         if_req = 1'b0; if_busy = 0; if_stim_q.delete();
         d_req  = 1'b0; d_busy  = 0; d_stim_q.delete();
      end else begin
         if (rv_pending) begin
            if (rv_wait == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rd(rv_addr);
               rv_pending = 0;
               chk("rvalid_with_req", 32'(mem_req), 32'h0);
            end else rv_wait--;
         end
         if (mem_req) begin
            if (cmd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_cmd: got addr %h expected no command", mem_addr);
            end else begin
               chk("cmd_we", 32'(mem_we), 32'(cmd_q[0].we));
               chk("cmd_addr", mem_addr, cmd_q[0].addr);
               chk("cmd_be", 32'(mem_be), 32'(cmd_q[0].be));
               if (cmd_q[0].we) chk("cmd_wdata", mem_wdata, cmd_q[0].wdata);
            end
            if (gcnt == gnt_delay) begin
               logic [31:0] w;
               mem_gnt = 1'b1; gcnt = 0;
               rv_pending = 1; rv_wait = rv_delay; rv_addr = mem_addr;
               if (mem_we) begin
                  w = rd(mem_addr);
                  for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                  mem_model[mem_addr] = w;
               end
               if (cmd_q.size() > 0) void'(cmd_q.pop_front());
               $display("cmd granted we=%0d addr=%h be=%h cycle=%0d", mem_we, mem_addr, mem_be, cycle_cnt - t0);
            end else gcnt++;
         end else gcnt = 0;

         if (if_busy && if_done) begin
            if (if_stim_q.size() > 0) begin
               if_cur = if_stim_q.pop_front(); if_addr = if_cur.addr; if_age = 0;
            end else begin
               if_req = 1'b0; if_busy = 0;
            end
         end else if (if_busy) begin
            if_age++;
            if (if_cur.drop_after > 0 && if_age == if_cur.drop_after) if_req = 1'b0;
         end else if (if_stim_q.size() > 0) begin
            if_cur = if_stim_q.pop_front(); if_addr = if_cur.addr; if_age = 0;
            if_req = 1'b1; if_busy = 1;
         end

         if (d_busy && d_done) begin
            if (d_stim_q.size() > 0) begin
               d_cur = d_stim_q.pop_front(); d_age = 0;
               d_we = d_cur.we; d_addr = d_cur.addr; d_wdata = d_cur.wdata; d_be = d_cur.be;
            end else begin
               d_req = 1'b0; d_busy = 0;
            end
         end else if (d_busy) begin
            d_age++;
            if (d_cur.drop_after > 0 && d_age == d_cur.drop_after) d_req = 1'b0;
         end else if (d_stim_q.size() > 0) begin
            d_cur = d_stim_q.pop_front(); d_age = 0;
            d_we = d_cur.we; d_addr = d_cur.addr; d_wdata = d_cur.wdata; d_be = d_cur.be;
            d_req = 1'b1; d_busy = 1;
         end
      end
      #2;
      if (if_stall)  if_stall_cyc++;
      if (mem_stall) mem_stall_cyc++;
      if (mem_req)   mem_req_cyc++;
      if (if_done)   take_done(1'b0, if_rdata);
      if (d_done)    take_done(1'b1, d_rdata);
   end

   task automatic start_test(input int gd, input int rdl);
      @(posedge clk); #2;
      gnt_delay = gd; rv_delay = rdl; t0 = cycle_cnt;
      if_stall_cyc = 0; mem_stall_cyc = 0; mem_req_cyc = 0;
   endtask

   task automatic push_if(input logic [31:0] a, input int drop);
      if_stim_q.push_back('{1'b0, a, 32'h0, 4'hF, drop});
   endtask

   task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      d_stim_q.push_back('{we, a, wd, be, 0});
   endtask

   task automatic exp_cmd(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      cmd_q.push_back('{we, a, wd, be});
   endtask

   task automatic exp_resp(input bit is_d, input bit cd, input logic [31:0] data, input int cyc);
      resp_q.push_back('{is_d, cd, data, cyc});
   endtask

   task automatic wait_idle(input string name);
      bit ok = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         if (resp_q.size() == 0 && !if_busy && !d_busy) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got %0d responses pending expected 0", name, resp_q.size());
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
      chk({tag, "_mem_addr"}, mem_addr, 32'h0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      chk({tag, "_mem_be"}, 32'(mem_be), 32'h0);
      chk({tag, "_if_done"}, 32'(if_done), 32'h0);
      chk({tag, "_d_done"}, 32'(d_done), 32'h0);
      chk({tag, "_if_rdata"}, if_rdata, 32'h0);
      chk({tag, "_d_rdata"}, d_rdata, 32'h0);
      chk({tag, "_run_cnt"}, 32'(dut.u_prio.run_cnt_q), 32'h0);
   endtask

   initial begin
      mem_model[32'h3000] = 32'h2408000A;
      mem_model[32'h3004] = 32'h8C090010;
      mem_model[32'h3008] = 32'h01095020;
      mem_model[32'h3010] = 32'hAC0A0014;
      mem_model[32'h0014] = 32'hFFFFFFFF;
      mem_model[32'h0020] = 32'h11112222;
      for (int k = 0; k < 5; k++) mem_model[32'h40 + 32'(4*k)] = 32'hA0000040 + 32'(4*k);
      for (int k = 0; k < 3; k++) mem_model[32'h60 + 32'(4*k)] = 32'hB0000060 + 32'(4*k);

      repeat (3) @(posedge clk); #1;
      chk_reset_outputs("init");
      chk("init_if_stall", 32'(if_stall), 32'h0);
      @(posedge clk); #2 rst = 1'b1;
      repeat (2) @(posedge clk);

      // single fetch
      start_test(0, 0);
      push_if(32'h3000, 0);
      exp_cmd(1'b0, 32'h3000, 32'h0, 4'hF);
      exp_resp(1'b0, 1'b1, 32'h2408000A, 3);
      wait_idle("fetch");
      chk("fetch_if_stall_cycles", 32'(if_stall_cyc), 32'd3);
      chk("fetch_mem_req_cycles", 32'(mem_req_cyc), 32'd1);
      chk("fetch_if_rdata_held", if_rdata, 32'h2408000A);

      // store with grant delayed two cycles
      start_test(2, 0);
      push_d(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      exp_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      exp_resp(1'b1, 1'b0, 32'h0, 5);
      wait_idle("store");
      chk("store_issue_cycles", 32'(mem_req_cyc), 32'd3);
      chk("store_mem_stall_cycles", 32'(mem_stall_cyc), 32'd5);
      chk("store_mem_word", rd(32'h10), 32'hDEADBEEF);

      // partial store then load back, one extra rvalid delay cycle each
      start_test(0, 1);
      push_d(1'b1, 32'h14, 32'h12345678, 4'h5);
      push_d(1'b0, 32'h14, 32'h0, 4'hF);
      exp_cmd(1'b1, 32'h14, 32'h12345678, 4'h5);
      exp_cmd(1'b0, 32'h14, 32'h0, 4'hF);
      exp_resp(1'b1, 1'b0, 32'h0, 4);
      exp_resp(1'b1, 1'b1, 32'hFF34FF78, 9);
      wait_idle("partial");

      // contention: data wins, fetch follows
      start_test(0, 0);
      push_d(1'b0, 32'h20, 32'h0, 4'hF);
      push_if(32'h3004, 0);
      exp_cmd(1'b0, 32'h20, 32'h0, 4'hF);
      exp_cmd(1'b0, 32'h3004, 32'h0, 4'hF);
      exp_resp(1'b1, 1'b1, 32'h11112222, 3);
      exp_resp(1'b0, 1'b1, 32'h8C090010, 7);
      wait_idle("contention");
      chk("cont_mem_stall_cycles", 32'(mem_stall_cyc), 32'd3);
      chk("cont_if_stall_cycles", 32'(if_stall_cyc), 32'd7);
      chk("cont_d_rdata_held", d_rdata, 32'h11112222);

      // fairness: four data grants, then the fetch, then data resumes
      start_test(0, 0);
      for (int k = 0; k < 5; k++) push_d(1'b0, 32'h40 + 32'(4*k), 32'h0, 4'hF);
      push_if(32'h3010, 0);
      for (int k = 0; k < 4; k++) exp_cmd(1'b0, 32'h40 + 32'(4*k), 32'h0, 4'hF);
      exp_cmd(1'b0, 32'h3010, 32'h0, 4'hF);
      exp_cmd(1'b0, 32'h50, 32'h0, 4'hF);
      for (int k = 0; k < 4; k++) exp_resp(1'b1, 1'b1, 32'hA0000040 + 32'(4*k), 3 + 4*k);
      exp_resp(1'b0, 1'b1, 32'hAC0A0014, 19);
      exp_resp(1'b1, 1'b1, 32'hA0000050, 23);
      wait_idle("fairness");
      chk("fair_if_stall_cycles", 32'(if_stall_cyc), 32'd19);
      chk("fair_mem_req_cycles", 32'(mem_req_cyc), 32'd6);

      // flush: fetch request dropped while waiting for rvalid
      start_test(0, 0);
      push_if(32'h3008, 2);
      exp_cmd(1'b0, 32'h3008, 32'h0, 4'hF);
      exp_resp(1'b0, 1'b1, 32'h01095020, 3);
      wait_idle("flush");
      repeat (4) @(posedge clk);
      chk("flush_mem_req_cycles", 32'(mem_req_cyc), 32'd1);
      chk("flush_if_stall_cycles", 32'(if_stall_cyc), 32'd2);

      // reset while the third data load waits for rvalid
      start_test(0, 0);
      for (int k = 0; k < 3; k++) push_d(1'b0, 32'h60 + 32'(4*k), 32'h0, 4'hF);
      push_if(32'h300C, 0);
      for (int k = 0; k < 3; k++) exp_cmd(1'b0, 32'h60 + 32'(4*k), 32'h0, 4'hF);
      exp_resp(1'b1, 1'b1, 32'hB0000060, 3);
      exp_resp(1'b1, 1'b1, 32'hB0000064, 7);
      repeat (10) @(posedge clk); #2;
      chk("rst_run_cnt_before", 32'(dut.u_prio.run_cnt_q), 32'd3);
      chk("rst_d_rdata_before", d_rdata, 32'hB0000064);
      rst = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);

      start_test(0, 0);
      push_if(32'h3008, 0);
      exp_cmd(1'b0, 32'h3008, 32'h0, 4'hF);
      exp_resp(1'b0, 1'b1, 32'h01095020, 3);
      wait_idle("post_reset");
      chk("post_reset_if_stall_cycles", 32'(if_stall_cyc), 32'd3);
      chk("post_reset_run_cnt", 32'(dut.u_prio.run_cnt_q), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
